// File: rtl/ob_pkg.sv
// ob_pkg: shared order-book types plus the market-queue depth and pointer type.
`default_nettype none

package ob_pkg;

    localparam int UID_W   = 16;
    localparam int PRICE_W = 16;
    localparam int QTY_W   = 16;

    typedef logic [UID_W-1:0]   uid_t;
    typedef logic [PRICE_W-1:0] price_t;
    typedef logic [QTY_W-1:0]   quantity_t;

    typedef struct packed {
        uid_t      uid;
        price_t    price;
        quantity_t quantity;
    } table_t;

    localparam int MK_QUEUE_N     = 16;
    localparam int MK_QUEUE_PTR_W = $clog2(MK_QUEUE_N) + 1;

    typedef logic [MK_QUEUE_PTR_W-1:0] mk_queue_ptr_t;

    function automatic logic qty_is_zero(input quantity_t q);
        return (q == '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ob_mk_queue_fifo.sv
// ob_mk_queue_fifo: circular backing store for the market queue, pointers one bit
// wider than the index; empty/full are registered from next-state pointers.
`default_nettype none

module ob_mk_queue_fifo
    import ob_pkg::*;
#(
    parameter int N = MK_QUEUE_N
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  table_t push_data_i,
    input  logic   pop_i,
    output table_t rd_data_o,
    output logic   empty_o,
    output logic   full_o
);

    localparam int IDX_W = $clog2(N);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             w_push, w_pop;
    table_t           mem_q [N];

    assign w_push = push_i & ~full_q;
    assign w_pop  = pop_i & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, w_push};
        rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, w_pop};
        empty_d  = (wr_ptr_d == rd_ptr_d);
        // Full: same slot index, opposite wrap bit.
        full_d   = (wr_ptr_d[IDX_W-1:0] == rd_ptr_d[IDX_W-1:0]) &&
                   (wr_ptr_d[IDX_W] != rd_ptr_d[IDX_W]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign empty_o   = empty_q;
    assign full_o    = full_q;

endmodule

`default_nettype wire

// File: rtl/ob_mk_queue.sv
// ob_mk_queue: market-order queue with registered head, trade-outcome update,
// occupancy and sticky overflow flag. OB_MK_QUEUE_BYPASS_EN enables empty-queue bypass.
`default_nettype none

module ob_mk_queue
    import ob_pkg::*;
#(
    parameter int N = MK_QUEUE_N
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_vld,
    input  table_t                   push,
    output logic                     full_r,
    output logic                     head_vld_r,
    output table_t                   head_r,
    input  logic                     upd_vld,
    input  logic                     upd_consumed,
    input  quantity_t                upd_remainder,
    output logic [$clog2(N+1):0]     occupancy_r,
    output logic                     err_ovf_r
);

    localparam int OCC_W = $clog2(N+1) + 1;

    table_t           head_q, head_d;
    logic             head_vld_q, head_vld_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             err_q, err_d;

    logic             w_fifo_full, w_fifo_empty, w_fifo_push;
    table_t           w_fifo_rd;
    logic             w_pop, w_partial, w_push_ok, w_head_load, w_bypass;

    assign w_pop       = upd_vld & head_vld_q & (upd_consumed | qty_is_zero(upd_remainder));
    assign w_partial   = upd_vld & head_vld_q & ~upd_consumed & ~qty_is_zero(upd_remainder);
    assign w_push_ok   = push_vld & ~w_fifo_full & ~qty_is_zero(push.quantity);
    assign w_head_load = (~head_vld_q | w_pop) & ~w_fifo_empty;

`ifdef OB_MK_QUEUE_BYPASS_EN
    assign w_bypass = w_push_ok & w_fifo_empty & (~head_vld_q | w_pop);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_fifo_push = w_push_ok & ~w_bypass;

    ob_mk_queue_fifo #(
        .N (N)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_fifo_push),
        .push_data_i (push),
        .pop_i       (w_head_load),
        .rd_data_o   (w_fifo_rd),
        .empty_o     (w_fifo_empty),
        .full_o      (w_fifo_full)
    );

    always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q;
        if (w_partial) begin
            head_d.quantity = upd_remainder;
        end
        // A load always implies the old head is gone (invalid or popped).
        if (w_head_load) begin
            head_d     = w_fifo_rd;
            head_vld_d = 1'b1;
        end else if (w_bypass) begin
            head_d     = push;
            head_vld_d = 1'b1;
        end else if (w_pop) begin
            head_vld_d = 1'b0;
        end
    end

    always_comb begin
        occ_d = occ_q + {{(OCC_W-1){1'b0}}, w_push_ok} - {{(OCC_W-1){1'b0}}, w_pop};
        err_d = err_q | (push_vld & w_fifo_full & ~qty_is_zero(push.quantity));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            head_vld_q <= 1'b0;
            occ_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
            occ_q      <= occ_d;
            err_q      <= err_d;
        end
    end

    assign head_r      = head_q;
    assign head_vld_r  = head_vld_q;
    assign occupancy_r = occ_q;
    assign err_ovf_r   = err_q;
    assign full_r      = w_fifo_full;

endmodule

`default_nettype wire

// File: tb/tb_ob_mk_queue.sv
// tb_ob_mk_queue: directed stimulus with a scoreboard queue; a negedge monitor
// checks the visible head against the oldest expected order.
`default_nettype none

module tb_ob_mk_queue;
    import ob_pkg::*;

    localparam int N     = 16;
    localparam int OCC_W = $clog2(N+1) + 1;
`ifdef OB_MK_QUEUE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push_vld = 1'b0;
    table_t           push = '0;
    logic             full_r;
    logic             head_vld_r;
    table_t           head_r;
    logic             upd_vld = 1'b0;
    logic             upd_consumed = 1'b0;
    quantity_t        upd_remainder = '0;
    logic [OCC_W-1:0] occupancy_r;
    logic             err_ovf_r;

    int     n_tests = 0;
    int     n_fail  = 0;
    table_t sb [$];

    ob_mk_queue #(.N(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .push_vld      (push_vld),
        .push          (push),
        .full_r        (full_r),
        .head_vld_r    (head_vld_r),
        .head_r        (head_r),
        .upd_vld       (upd_vld),
        .upd_consumed  (upd_consumed),
        .upd_remainder (upd_remainder),
        .occupancy_r   (occupancy_r),
        .err_ovf_r     (err_ovf_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input int uid, input int qty, input bit exp_acc);
        push_vld = 1'b1;
        push     = '{uid: uid_t'(uid), price: price_t'(uid + 100), quantity: quantity_t'(qty)};
        if (exp_acc) sb.push_back(push);
    endtask

    task automatic idle_push();
        push_vld = 1'b0;
        push     = '0;
    endtask

    task automatic set_upd(input logic v, input logic c, input int rem);
        upd_vld       = v;
        upd_consumed  = c;
        upd_remainder = quantity_t'(rem);
    endtask

    // Monitor: visible head must equal oldest expected order; then apply the update.
    always @(negedge clk) begin
        if (!rst && head_vld_r) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL head_unexpected: got uid %0d expected no head", head_r.uid);
            end else begin
                chk("head", head_r, sb[0]);
                if (upd_vld) begin
                    if (upd_consumed || upd_remainder == 0) begin
                        void'(sb.pop_front());
                    end else begin
                        table_t t;
                        t = sb[0];
                        t.quantity = upd_remainder;
                        sb[0] = t;
                    end
                end
            end
        end
    end

    initial begin
        #2;
        chk("rst_head_vld", head_vld_r, 0);
        chk("rst_head", head_r, 0);
        chk("rst_full", full_r, 0);
        chk("rst_occ", occupancy_r, 0);
        chk("rst_err", err_ovf_r, 0);
        #10 rst = 1'b0;

        // Fill to full
        for (int i = 1; i <= 17; i++) begin
            drive_push(i, 10, 1'b1);
            tick();
            if (i == 1) chk("lat_first_vld", head_vld_r, BYP);
            if (i == 2) begin
                chk("lat_second_vld", head_vld_r, 1);
                chk("lat_second_uid", head_r.uid, 1);
            end
        end
        idle_push();
        chk("fill_occ", occupancy_r, 17);
        chk("fill_full", full_r, 1);
        chk("fill_err", err_ovf_r, 0);

        // Overflow while full, then drain
        drive_push(18, 10, 1'b0);
        tick();
        idle_push();
        chk("ovf_err", err_ovf_r, 1);
        chk("ovf_occ", occupancy_r, 17);
        chk("ovf_full", full_r, 1);
        set_upd(1'b1, 1'b1, 0);
        repeat (17) tick();
        set_upd(1'b0, 1'b0, 0);
        chk("drain_occ", occupancy_r, 0);
        chk("drain_vld", head_vld_r, 0);
        chk("drain_full", full_r, 0);
        chk("drain_sb_left", sb.size(), 0);

        // Partial fill
        drive_push(5, 100, 1'b1);
        tick();
        drive_push(6, 30, 1'b1);
        tick();
        idle_push();
        tick();
        chk("pf_uid_before", head_r.uid, 5);
        chk("pf_qty_before", head_r.quantity, 100);
        chk("pf_occ_before", occupancy_r, 2);
        set_upd(1'b1, 1'b0, 40);
        tick();
        set_upd(1'b0, 1'b0, 0);
        chk("pf_uid", head_r.uid, 5);
        chk("pf_qty", head_r.quantity, 40);
        chk("pf_occ", occupancy_r, 2);

        // Zero remainder counts as consumed
        set_upd(1'b1, 1'b0, 0);
        tick();
        set_upd(1'b0, 1'b0, 0);
        chk("zr_vld", head_vld_r, 1);
        chk("zr_uid", head_r.uid, 6);
        chk("zr_occ", occupancy_r, 1);

        // Pop and push together on a single-entry queue
        set_upd(1'b1, 1'b1, 0);
        tick();
        set_upd(1'b0, 1'b0, 0);
        chk("pp_empty_vld", head_vld_r, 0);
        chk("pp_empty_occ", occupancy_r, 0);
        drive_push(7, 15, 1'b1);
        tick();
        idle_push();
        tick();
        chk("pp_head7_uid", head_r.uid, 7);
        chk("pp_head7_occ", occupancy_r, 1);
        set_upd(1'b1, 1'b1, 0);
        drive_push(8, 20, 1'b1);
        tick();
        set_upd(1'b0, 1'b0, 0);
        idle_push();
`ifdef OB_MK_QUEUE_BYPASS_EN
        chk("pp_byp_vld", head_vld_r, 1);
        chk("pp_byp_uid", head_r.uid, 8);
`else
        chk("pp_bubble_vld", head_vld_r, 0);
`endif
        chk("pp_occ", occupancy_r, 1);
        tick();
        chk("pp_head8_vld", head_vld_r, 1);
        chk("pp_head8_uid", head_r.uid, 8);

        // Asynchronous reset mid-operation
        drive_push(9, 11, 1'b1);
        tick();
        drive_push(10, 12, 1'b1);
        tick();
        idle_push();
        chk("mr_occ_before", occupancy_r, 3);
        set_upd(1'b1, 1'b0, 5);
        #2 rst = 1'b1;
        #1;
        chk("mr_vld", head_vld_r, 0);
        chk("mr_head", head_r, 0);
        chk("mr_occ", occupancy_r, 0);
        chk("mr_full", full_r, 0);
        chk("mr_err", err_ovf_r, 0);
        sb.delete();
        set_upd(1'b0, 1'b0, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        tick();
        drive_push(12, 7, 1'b1);
        tick();
        idle_push();
        chk("mr_lat_first_vld", head_vld_r, BYP);
        tick();
        chk("mr_lat_vld", head_vld_r, 1);
        chk("mr_lat_uid", head_r.uid, 12);
        chk("mr_lat_occ", occupancy_r, 1);
        set_upd(1'b1, 1'b1, 0);
        tick();
        set_upd(1'b0, 1'b0, 0);
        chk("mr_pop_vld", head_vld_r, 0);

        // Zero-quantity push is dropped silently
        drive_push(13, 0, 1'b0);
        tick();
        idle_push();
        tick();
        chk("zq_occ", occupancy_r, 0);
        chk("zq_err", err_ovf_r, 0);
        chk("zq_vld", head_vld_r, 0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ob_mk_queue.md
# ob_mk_queue

Holds pending market orders for one side of the book (instantiated twice: market buy and market sell). It presents the oldest order as a registered head to the market-trade controller, which consumes it as `mk_buy_head_*` / `mk_sell_head_*`. The queue applies the controller's trade outcome each cycle: it pops a consumed head, or rewrites the head quantity with the trade remainder. Orders enter from the command decode stage in arrival order.

## Interface

**Parameters**
- `N`, default 16: depth of backing storage in entries, excluding the head register; power of two, ≥ 2.

**Ports**
- Clock and reset: one clock; reset is asynchronous and active-high. Ports are named `clk` and `rst`.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `push_vld`  in  1  new market order present.
- `push`  in  `ob_pkg::table_t`  order: uid, price, quantity.
- `full_r`  out  1  storage holds N entries; a push this cycle is dropped.
- `head_vld_r`  out  1  head register valid.
- `head_r`  out  `ob_pkg::table_t`  oldest order, with quantity reflecting partial fills.
- `upd_vld`  in  1  trade outcome for the current head.
- `upd_consumed`  in  1  head fully filled; pop it.
- `upd_remainder`  in  `ob_pkg::quantity_t`  residual head quantity when not consumed.
- `occupancy_r`  out  `$clog2(N+1)+1`  head plus stored entries.
- `err_ovf_r`  out  1  sticky: a push was dropped while full.

## Operation

- Storage is a circular FIFO with read/write pointers one bit wider than the index.
  - Empty: pointers are equal.
  - Full: pointers differ only in the MSB.
- Head register load, at each edge:
  - The head loads from the FIFO when (`!head_vld_r` or pop) and the FIFO is non-empty.
  - FIFO write and head load in the same cycle are independent.
  - A push into a full FIFO when a same-cycle head load frees a slot is still dropped, because `full_r` is registered.
- Pop: `upd_vld & head_vld_r & (upd_consumed | upd_remainder == 0)`.
  - A zero remainder with `upd_consumed=0` is treated as consumed.
- Partial fill: `upd_vld & head_vld_r & !upd_consumed & upd_remainder != 0` writes `head_r.quantity <= upd_remainder`. Uid and price are unchanged.
- `upd_vld` while `!head_vld_r` is ignored.
- Push while `full_r` is dropped: FIFO contents are unchanged and `err_ovf_r` is set to 1 until reset.
- A push with quantity 0 is dropped silently; no error is raised.
- `occupancy_r` next value = current + accepted push − pop. It saturates at neither end; the legal range is 0..N+1.
- On reset mid-operation, all entries are discarded. The storage array is not cleared.

## Timing

- Reset values:
  - `head_vld_r=0`, `head_r='0`.
  - `full_r=0`, `occupancy_r=0`, `err_ovf_r=0`.
  - Pointers = 0.
- Push to `head_vld_r` latency on an empty queue:
  - 2 cycles: FIFO write, then head load.
  - 1 cycle with the bypass (see Configuration).
- Pop with the FIFO non-empty: `head_vld_r` stays 1 and the next entry is visible the following cycle, with no bubble.
- Partial fill: the new quantity is visible on `head_r` the following cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration

- `OB_MK_QUEUE_BYPASS_EN` defined:
  - Condition: the FIFO is empty and (`!head_vld_r` or pop).
  - Effect: an accepted push loads the head register directly and is not written to the FIFO.
  - Result: head latency is 1 cycle, including a same-cycle pop-and-push on a single-entry queue.
- `OB_MK_QUEUE_BYPASS_EN` undefined: every push goes through the FIFO, giving 2-cycle latency.
- Occupancy, full and error semantics are identical in both builds.

## Structure

- `ob_pkg` gains `MK_QUEUE_N` (default depth) and `mk_queue_ptr_t`.
  - `table_t` and `quantity_t` already live in `ob_pkg`.
- One sub-module, `ob_mk_queue_fifo`, holds the storage array and pointers. Its interface is push, pop, empty and full, plus read data.
- `ob_mk_queue` owns the head register, update logic, occupancy and error flag.

## Test plan

1. **Fill to full:** reset, then push uids 1..17 (N=16), quantity 10, one per cycle.
   - Head uid 1 is valid on cycle 2, or cycle 1 with bypass.
   - `occupancy_r` reaches 17 and `full_r=1`.
2. **Overflow while full:** from the full state, push uid 18.
   - `err_ovf_r=1` and `occupancy_r` stays 17.
   - Popping all entries drains uids 1..17 in order; uid 18 never appears.
3. **Partial fill:** head uid 5 quantity 100; `upd_vld=1`, `upd_consumed=0`, `upd_remainder=40`.
   - Next cycle `head_r` is uid 5, quantity 40.
   - `occupancy_r` is unchanged.
4. **Zero remainder counts as consumed:** `upd_consumed=0`, `upd_remainder=0` on head uid 5 with uid 6 queued.
   - Next cycle the head is uid 6 and occupancy is decremented.
5. **Pop and push together:** a single head uid 7 with the FIFO empty; same cycle, pop plus push uid 8.
   - Bypass build: head uid 8 next cycle.
   - Non-bypass build: `head_vld_r=0` for one cycle, then uid 8.
6. **Reset mid-operation:** with 3 entries and a partial update pending, assert `rst` asynchronously mid-cycle.
   - All outputs are 0 immediately.
   - After release, the first push behaves as on an empty queue.
